// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared fetch-stage types and constants
package rv32i_pkg;

    localparam int unsigned InstrBytes = 4;
    localparam int unsigned Xlen       = 32;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [Xlen-1:0] pc;
        logic [Xlen-1:0] instr;
    } fetch_slot_t;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory and decode-side handshake bundle
interface fetch_unit_if #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32
) ();

    logic                 imem_req;
    logic [AddrWidth-1:0] imem_addr;
    logic                 imem_gnt;
    logic                 imem_rvalid;
    logic [DataWidth-1:0] imem_rdata;

    logic                 if_valid;
    logic                 if_ready;
    logic [AddrWidth-1:0] if_pc;
    logic [DataWidth-1:0] if_instr;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output if_valid, if_pc, if_instr,
        input  if_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  if_valid, if_pc, if_instr,
        output if_ready
    );

endinterface

// File: rtl/fetch_slot.sv
// rtl/fetch_slot.sv - one-entry valid/ready holding register with synchronous flush
module fetch_slot #(
    parameter int Width = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             wr_en_i,
    input  logic [Width-1:0] wr_data_i,
    input  logic             rd_ready_i,
    output logic             rd_valid_o,
    output logic [Width-1:0] rd_data_o
);

    logic             valid_q, valid_d;
    logic [Width-1:0] data_q, data_d;

    // Flush wins over a same-cycle write; a consumed entry frees the slot.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q && rd_ready_i) begin
            valid_d = 1'b0;
        end
        if (wr_en_i) begin
            valid_d = 1'b1;
            data_d  = wr_data_i;
        end
        if (flush_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign rd_valid_o = valid_q;
    assign rd_data_o  = data_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I fetch stage: pc, single-outstanding imem fetch, redirect handling
module fetch_unit
    import rv32i_pkg::*;
#(
    parameter int                   DataWidth = 32,
    parameter int                   AddrWidth = 32,
    parameter logic [AddrWidth-1:0] ResetPc   = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 redirect_en,
    input  logic [AddrWidth-1:0] redirect_pc,
    output logic                 misaligned,
    fetch_unit_if.master         bus
);

    fetch_state_e         state_q, state_d;
    logic [AddrWidth-1:0] pc_q, pc_d;
    logic [AddrWidth-1:0] req_pc_q, req_pc_d;

    logic                 slot_valid;
    logic                 slot_free;
    logic                 slot_wr;
    logic                 fire;
    logic [AddrWidth-1:0] redirect_target;
    logic [AddrWidth+DataWidth-1:0] slot_rd_data;

    assign redirect_target = {redirect_pc[AddrWidth-1:2], 2'b00};
    assign slot_free       = !slot_valid || bus.if_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= REQ;
            pc_q     <= ResetPc;
            req_pc_q <= ResetPc;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    // A grant taken in the redirect cycle belongs to the old path, so it must be drained.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        unique case (state_q)
            REQ: begin
                if (fire) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + AddrWidth'(InstrBytes);
                    state_d  = redirect_en ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_rvalid) begin
                    state_d = REQ;
                end else if (redirect_en) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.imem_rvalid) begin
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
        if (redirect_en) begin
            pc_d = redirect_target;
        end
    end

    always_comb begin
        bus.imem_req  = !rst && (state_q == REQ) && slot_free;
        bus.imem_addr = pc_q;
        fire          = bus.imem_req && bus.imem_gnt;
        slot_wr       = (state_q == WAIT) && bus.imem_rvalid && !redirect_en;
        misaligned    = !rst && redirect_en && (redirect_pc[1:0] != 2'b00);
    end

    fetch_slot #(
        .Width(AddrWidth + DataWidth)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (redirect_en),
        .wr_en_i   (slot_wr),
        .wr_data_i ({req_pc_q, bus.imem_rdata}),
        .rd_ready_i(bus.if_ready),
        .rd_valid_o(slot_valid),
        .rd_data_o (slot_rd_data)
    );

    assign bus.if_valid = slot_valid;
    assign bus.if_pc    = slot_rd_data[AddrWidth+DataWidth-1:DataWidth];
    assign bus.if_instr = slot_rd_data[DataWidth-1:0];

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RV32I core: owns the program counter, issues word fetches to instruction memory over a request/grant/response handshake, and presents fetched instructions to decode through a valid/ready port. It consumes the resolved control-flow decision from execute (branch comparator result gated with branch/jump decode) as a redirect, discarding wrong-path fetches in flight.

## Interface
- DataWidth, 32, instruction word width
- AddrWidth, 32, PC / fetch address width
- ResetPc, 32'h0000_0000, first fetch address after reset

- clk  in  1  core clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- redirect_en  in  1  taken branch/jump resolved this cycle
- redirect_pc  in  AddrWidth  target address for redirect
- imem_req  out  1  fetch request valid
- imem_addr  out  AddrWidth  fetch address (= pc)
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response data valid (one per grant, in order)
- imem_rdata  in  DataWidth  fetched instruction
- if_valid  out  1  instruction available to decode
- if_ready  in  1  decode accepts instruction
- if_pc  out  AddrWidth  address of presented instruction
- if_instr  out  DataWidth  presented instruction
- misaligned  out  1  one-cycle pulse: redirect_pc[1:0] != 0

## Operation
- Single outstanding request; one-entry output slot holding {pc, instr}.
- States: REQ, WAIT, DRAIN.
- REQ: imem_req = 1 when slot empty or (if_valid && if_ready) this cycle. On imem_req && imem_gnt: latch req_pc = pc, pc <= pc + 4 (wraps mod 2^AddrWidth), -> WAIT.
- WAIT: on imem_rvalid: slot <= {req_pc, imem_rdata}, -> REQ. Slot is guaranteed empty at capture.
- DRAIN: on imem_rvalid: response dropped, -> REQ.
- Redirect (priority over all else, any state): pc <= {redirect_pc[AddrWidth-1:2], 2'b00}; slot cleared (if_valid = 0 next cycle, a same-cycle handshake still counts as consumed); REQ without grant -> REQ; REQ with grant same cycle -> DRAIN (granted fetch is wrong-path); WAIT -> DRAIN, unless imem_rvalid same cycle -> REQ (response dropped); DRAIN stays DRAIN unless imem_rvalid same cycle -> REQ.
- misaligned pulses with redirect_en when redirect_pc[1:0] != 0; address still aligned down.
- imem_addr may change while imem_req is held ungranted only due to redirect.

## Timing
- Reset (async assert): pc = ResetPc, state = REQ, slot empty, if_valid = 0, imem_req = 0, misaligned = 0, if_pc/if_instr = 0.
- First cycle after reset deassertion: imem_req = 1, imem_addr = ResetPc.
- Latency: grant cycle N, rvalid cycle N+k (k >= 1), if_valid high cycle N+k+1.
- Throughput with k = 1 and if_ready held high: one instruction per 2 cycles.
- Slot holds stable if_pc/if_instr while if_valid && !if_ready.
- Reset mid-transaction: outstanding response after reset is not expected; memory is reset together.

## Structure
- rv32i_pkg: fetch_state_e {REQ, WAIT, DRAIN}; InstrBytes = 4; fetch slot struct {pc, instr}.
- Sub-module fetch_slot: one-entry valid/ready register with synchronous flush input.
- FSM, pc register and redirect logic in fetch_unit.

## Test plan
- Reset release, gnt/rvalid always 1-cycle -> imem_addr 0x0, 0x4, 0x8; if_pc 0x0, 0x4, 0x8 in order with matching rdata.
- if_ready low 5 cycles with slot full -> if_pc/if_instr stable, imem_req = 0, no new grant; resumes at next address.
- redirect_en to 0x100 while in WAIT for 0x8 -> 0x8 response dropped, next imem_addr 0x100, next if_pc 0x100.
- redirect_en to 0x200 in same cycle as grant for 0xC -> enter DRAIN, 0xC dropped, next request 0x200.
- pc = 0xFFFF_FFFC granted -> next imem_addr 0x0000_0000.
- redirect_pc = 0x0000_0106 -> misaligned pulses 1 cycle, next imem_addr 0x104.
